// File: rtl/pcm_frame_scheduler.sv
// Frame-committed byte FIFO behind the PCM decoder, with a ready/valid packetiser
// that interleaves framed telemetry packets and a periodic status packet.
module pcm_frame_scheduler #(
  parameter int unsigned FRAME_SIZE    = 128,
  parameter int unsigned FIFO_DEPTH    = 512,
  parameter int unsigned STATUS_PERIOD = 10240000,
  parameter logic [7:0]  FRAME_HDR     = 8'hA5,
  parameter logic [7:0]  STATUS_HDR    = 8'h5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_en,
  input  logic        lock,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] frames_rx,
  output logic [7:0]  drop_count,
  output logic        busy
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LIM_I = FIFO_DEPTH - FRAME_SIZE;
  localparam logic [AW:0] LIM   = LIM_I[AW:0];
  localparam logic [AW:0] PONE  = (AW+1)'(1);
  localparam logic [7:0]  LAST  = 8'(FRAME_SIZE - 1);
  localparam logic [31:0] TMAX  = 32'(STATUS_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, F_HDR, F_SEQ, F_DATA, S_HDR, S_CNT, S_FLAGS} state_t;

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_commit_ptr, r_rd_ptr, r_fpend;
  logic [7:0]  r_byte_cnt, r_drop_cnt, r_seq, r_dcnt, r_snap;
  logic        r_drop, r_lock_q, r_stat_pend;
  logic [15:0] r_frames_rx;
  logic [31:0] r_tmr;
  state_t      r_state, w_next;

  logic [AW:0] w_used;
  logic        w_acc, w_last, w_drop, w_wr, w_commit, w_rollback, w_drop_evt, w_tc;
  logic        w_valid, w_xfer, w_done, w_rd_adv, w_enter_shdr;
  logic [7:0]  w_data;

  assign w_acc      = in_en & lock;
  assign w_last     = (r_byte_cnt == LAST);
  assign w_used     = r_commit_ptr - r_rd_ptr;
  // Drop decision is made on the first byte and held for the rest of the frame.
  assign w_drop     = (r_byte_cnt == 8'd0) ? (w_used > LIM) : r_drop;
  assign w_wr       = w_acc & ~w_drop;
  assign w_commit   = w_acc & w_last & ~w_drop;
  assign w_rollback = r_lock_q & ~lock & (r_byte_cnt != 8'd0);
  assign w_drop_evt = (w_acc & w_last & w_drop) | w_rollback;
  assign w_tc       = (r_tmr == TMAX);
  assign w_xfer     = w_valid & out_ready;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_q     <= 1'b0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_byte_cnt   <= '0;
      r_drop       <= 1'b0;
      r_frames_rx  <= '0;
      r_drop_cnt   <= '0;
      r_fpend      <= '0;
    end else begin
      r_lock_q <= lock;
      if (w_rollback) begin
        r_wr_ptr   <= r_commit_ptr;
        r_byte_cnt <= '0;
        r_drop     <= 1'b0;
      end else if (w_acc) begin
        if (w_wr) r_wr_ptr <= r_wr_ptr + PONE;
        if (w_last) begin
          r_byte_cnt <= '0;
          r_drop     <= 1'b0;
        end else begin
          r_byte_cnt <= r_byte_cnt + 8'd1;
          r_drop     <= w_drop;
        end
        if (w_commit) begin
          r_commit_ptr <= r_wr_ptr + PONE;
          r_frames_rx  <= r_frames_rx + 16'd1;
        end
      end
      if (w_drop_evt && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      case ({w_commit, w_done})
        2'b10:   r_fpend <= r_fpend + PONE;
        2'b01:   r_fpend <= r_fpend - PONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr       <= '0;
      r_stat_pend <= 1'b0;
    end else begin
      r_tmr <= w_tc ? '0 : r_tmr + 32'd1;
      // A request landing on the same cycle as S_HDR entry is kept, not lost.
      if (w_tc) r_stat_pend <= 1'b1;
      else if (w_enter_shdr) r_stat_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_seq    <= '0;
      r_dcnt   <= '0;
      r_snap   <= '0;
    end else begin
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + PONE;
        r_dcnt   <= w_done ? 8'd0 : r_dcnt + 8'd1;
      end
      if (w_done) r_seq <= r_seq + 8'd1;
      // Status fields are snapshotted so out_data cannot move during a stall.
      if (r_state == S_HDR && w_xfer) r_snap <= r_drop_cnt;
      if (r_state == S_CNT && w_xfer) r_snap <= {6'b0, r_fpend != '0, lock};
    end
  end

  always_comb begin
    w_next       = r_state;
    w_valid      = 1'b0;
    w_data       = '0;
    w_done       = 1'b0;
    w_rd_adv     = 1'b0;
    w_enter_shdr = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_stat_pend) begin
          w_next       = S_HDR;
          w_enter_shdr = 1'b1;
        end else if (r_fpend != '0) begin
          w_next = F_HDR;
        end
      end
      F_HDR: begin
        w_valid = 1'b1;
        w_data  = FRAME_HDR;
        if (out_ready) w_next = F_SEQ;
      end
      F_SEQ: begin
        w_valid = 1'b1;
        w_data  = r_seq;
        if (out_ready) w_next = F_DATA;
      end
      F_DATA: begin
        w_valid = 1'b1;
        w_data  = r_mem[r_rd_ptr[AW-1:0]];
        if (out_ready) begin
          w_rd_adv = 1'b1;
          if (r_dcnt == LAST) begin
            w_done = 1'b1;
            w_next = IDLE;
          end
        end
      end
      S_HDR: begin
        w_valid = 1'b1;
        w_data  = STATUS_HDR;
        if (out_ready) w_next = S_CNT;
      end
      S_CNT: begin
        w_valid = 1'b1;
        w_data  = r_snap;
        if (out_ready) w_next = S_FLAGS;
      end
      S_FLAGS: begin
        w_valid = 1'b1;
        w_data  = r_snap;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign out_valid  = w_valid;
  assign out_data   = w_data;
  assign busy       = (r_state != IDLE);
  assign frames_rx  = r_frames_rx;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_pcm_frame_scheduler.sv
// Directed bench for pcm_frame_scheduler: a packet-parsing monitor splits the
// output into frame and status bytes, and the main sequence checks them.
module tb_pcm_frame_scheduler;

  localparam int FS = 128;

  logic        clk = 1'b0;
  logic        reset, in_en, lock, out_ready, out_valid, busy;
  logic [7:0]  in_data, out_data, drop_count;
  logic [15:0] frames_rx;

  int total = 0;
  int bad   = 0;
  bit rnd   = 1'b0;

  logic [7:0] got_q[$];
  logic [7:0] st_q[$];
  int         st_cyc[$];
  int         cyc_n = 0;
  int         hdr_err = 0;
  int         stall_err = 0;
  int         stall_seen = 0;
  int         mpos = 0;
  logic [7:0] mkind = '0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  pcm_frame_scheduler #(
    .FRAME_SIZE(FS),
    .FIFO_DEPTH(512),
    .STATUS_PERIOD(100),
    .FRAME_HDR(8'hA5),
    .STATUS_HDR(8'h5A)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_en(in_en),
    .lock(lock),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frames_rx(frames_rx),
    .drop_count(drop_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  always @(negedge clk) begin
    if (reset) begin
      mpos       = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_seen++;
        if (!out_valid || out_data !== prev_data) stall_err++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (mpos == 0) begin
          mkind = out_data;
          if (out_data == 8'h5A) st_cyc.push_back(cyc_n);
          else if (out_data != 8'hA5) hdr_err++;
          mpos = 1;
        end else if (mkind == 8'hA5) begin
          got_q.push_back(out_data);
          mpos = (mpos == FS + 1) ? 0 : mpos + 1;
        end else begin
          st_q.push_back(out_data);
          mpos = (mpos == 2) ? 0 : mpos + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [7:0] exp_byte(input int kind, input int k, input int i);
    case (kind)
      0:       return 8'(i);
      1:       return 8'(8'h80 + i);
      2:       return 8'(k + i);
      3:       return 8'(i * 3 + 1);
      default: return 8'(255 - i);
    endcase
  endfunction

  task automatic send(input int kind, input int k, input int n);
    for (int i = 0; i < n; i++) begin
      in_data = exp_byte(kind, k, i);
      in_en   = 1'b1;
      cyc();
    end
    in_en = 1'b0;
  endtask

  task automatic wait_got(input int n, input int lim);
    for (int c = 0; c < lim && got_q.size() < n; c++) cyc();
  endtask

  task automatic chk_frame(input string tag, input int base, input logic [7:0] seq,
                           input int kind, input int k);
    int b0;
    chk({tag, "_avail"}, 32'(got_q.size() >= base + FS + 1), 32'd1);
    if (got_q.size() >= base + FS + 1) begin
      chk({tag, "_seq"}, 32'(got_q[base]), 32'(seq));
      b0 = bad;
      for (int i = 0; i < FS && bad == b0; i++)
        chk($sformatf("%s_d%0d", tag, i), 32'(got_q[base + 1 + i]), 32'(exp_byte(kind, k, i)));
    end
  endtask

  initial begin
    int gb, sb, qb;
    reset = 1'b1; in_en = 1'b0; lock = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) cyc();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_frames", 32'(frames_rx), 32'd0);
    chk("rst_drops", 32'(drop_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    lock  = 1'b1;

    // Idle status packets: 5A,00,01 every 100 cycles
    sb = st_cyc.size(); qb = st_q.size();
    repeat (350) cyc();
    chk("st_num", 32'(st_cyc.size() - sb), 32'd3);
    if (st_cyc.size() - sb >= 3) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("st_cnt%0d", j), 32'(st_q[qb + 2 * j]), 32'd0);
        chk($sformatf("st_flg%0d", j), 32'(st_q[qb + 2 * j + 1]), 32'd1);
      end
      chk("st_gap1", 32'(st_cyc[sb + 1] - st_cyc[sb]), 32'd100);
      chk("st_gap2", 32'(st_cyc[sb + 2] - st_cyc[sb + 1]), 32'd100);
    end

    // Frame 0..127 with ready held high
    gb = got_q.size();
    send(0, 0, FS);
    wait_got(gb + 10, 300);
    chk("f1_busy_mid", 32'(busy), 32'd1);
    wait_got(gb + FS + 1, 500);
    chk_frame("f1", gb, 8'h00, 0, 0);
    chk("f1_frames", 32'(frames_rx), 32'd1);
    chk("f1_drops", 32'(drop_count), 32'd0);
    for (int c = 0; c < 10 && busy; c++) cyc();
    chk("f1_busy_end", 32'(busy), 32'd0);

    // Lock lost after 50 bytes, then a clean frame 0x80..0xFF
    gb = got_q.size();
    send(0, 0, 50);
    lock = 1'b0;
    repeat (2) cyc();
    lock = 1'b1;
    cyc();
    chk("rb_drops", 32'(drop_count), 32'd1);
    send(1, 0, FS);
    wait_got(gb + FS + 1, 500);
    chk("rb_len", 32'(got_q.size() - gb), 32'(FS + 1));
    chk_frame("rb", gb, 8'h01, 1, 0);
    chk("rb_frames", 32'(frames_rx), 32'd2);

    // Five frames while the sink is stalled: four fit, the fifth is dropped
    for (int c = 0; c < 10 && busy; c++) cyc();
    out_ready = 1'b0;
    gb = got_q.size();
    for (int k = 0; k < 5; k++) send(2, k, FS);
    chk("ff_frames", 32'(frames_rx), 32'd6);
    chk("ff_drops", 32'(drop_count), 32'd2);
    chk("ff_nodata", 32'(got_q.size() - gb), 32'd0);
    out_ready = 1'b1;
    wait_got(gb + 4 * (FS + 1), 1500);
    for (int k = 0; k < 4; k++)
      chk_frame($sformatf("ff%0d", k), gb + k * (FS + 1), 8'(2 + k), 2, k);
    chk("ff_len", 32'(got_q.size() - gb), 32'(4 * (FS + 1)));

    // Random backpressure
    gb = got_q.size();
    rnd = 1'b1;
    send(3, 0, FS);
    wait_got(gb + FS + 1, 2000);
    rnd = 1'b0;
    out_ready = 1'b1;
    chk_frame("rr", gb, 8'h06, 3, 0);
    chk("rr_stalls_seen", 32'(stall_seen > 0), 32'd1);
    chk("rr_stall_stable", 32'(stall_err), 32'd0);

    // Reset in the middle of frame data
    gb = got_q.size();
    send(0, 0, FS);
    wait_got(gb + 20, 500);
    chk("mr_in_data", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_frames", 32'(frames_rx), 32'd0);
    chk("mr_drops", 32'(drop_count), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    repeat (5) cyc();
    gb = got_q.size();
    chk("mr_empty", 32'(busy), 32'd0);
    send(4, 0, FS);
    wait_got(gb + FS + 1, 500);
    chk_frame("mr", gb, 8'h00, 4, 0);
    chk("mr_frames2", 32'(frames_rx), 32'd1);
    chk("mr_drops2", 32'(drop_count), 32'd0);
    chk("hdr_ok", 32'(hdr_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
